// File: rtl/capture_sequencer.sv
// Walks the move-generator core through victim/aggressor searches in MVV-LVA order
// and streams every discovered capture to the host over a valid/ready port.
module capture_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       illegal,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_data,
   input  logic [7:0] core_result,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [5:0] move_from,
   output logic [5:0] move_to,
   output logic [7:0] move_count
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_VWAIT, S_AWAIT, S_EMIT, S_ADIS, S_RESTORE, S_VDIS, S_DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   wait_q;
   logic [15:0]     cmd_q;
   logic [63:0]     agg_mask_q;
   logic [5:0]      victim_q;
   logic [5:0]      move_from_q;
   logic [5:0]      move_to_q;
   logic [7:0]      move_count_q;
   logic            busy_q;
   logic            done_q;
   logic            illegal_q;
   logic            move_valid_q;
   logic [5:0]      low_sq;

   function automatic logic [15:0] find_aggr(input logic [5:0] s);
      return {6'b111100, s[5:4], s[3:0], 4'h0};
   endfunction

   function automatic logic [15:0] set_en(input logic [5:0] s, input logic v);
      return {6'b110100, s[5:4], s[3:0], 3'b000, v};
   endfunction

   // Lowest masked aggressor square; restores walk the mask upward from bit 0.
   always_comb begin
      low_sq = 6'd0;
      for (int i = 63; i >= 0; i--) begin
         if (agg_mask_q[i]) low_sq = 6'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wait_q       <= '0;
         cmd_q        <= 16'h0000;
         agg_mask_q   <= 64'd0;
         victim_q     <= 6'd0;
         move_from_q  <= 6'd0;
         move_to_q    <= 6'd0;
         move_count_q <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         illegal_q    <= 1'b0;
         move_valid_q <= 1'b0;
      end else begin
         // Commands are single-cycle strobes; NOP unless a state drives one.
         cmd_q  <= 16'h0000;
         done_q <= 1'b0;
         if (abort) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            move_valid_q <= 1'b0;
            agg_mask_q   <= 64'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     illegal_q    <= 1'b0;
                     move_count_q <= 8'd0;
                     agg_mask_q   <= 64'd0;
                     busy_q       <= 1'b1;
                     cmd_q        <= 16'hC000;
                     state_q      <= S_INIT;
                  end
               end
               S_INIT: begin
                  cmd_q   <= 16'hE000;
                  wait_q  <= SETTLE_LD;
                  state_q <= S_VWAIT;
               end
               S_VWAIT: begin
                  if (wait_q != '0) begin
                     wait_q <= wait_q - 1'b1;
                  end else if (core_result[7]) begin
                     illegal_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= S_DONE;
                  end else if (core_result[6]) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     victim_q <= core_result[5:0];
                     cmd_q    <= find_aggr(core_result[5:0]);
                     wait_q   <= SETTLE_LD;
                     state_q  <= S_AWAIT;
                  end
               end
               S_AWAIT: begin
                  if (wait_q != '0) begin
                     wait_q <= wait_q - 1'b1;
                  end else if (core_result[6]) begin
                     state_q <= S_RESTORE;
                  end else begin
                     move_from_q  <= core_result[5:0];
                     move_to_q    <= victim_q;
                     move_valid_q <= 1'b1;
                     state_q      <= S_EMIT;
                  end
               end
               S_EMIT: begin
                  if (move_ready) begin
                     move_valid_q <= 1'b0;
                     if (move_count_q != 8'hFF) move_count_q <= move_count_q + 8'd1;
                     cmd_q                   <= set_en(move_from_q, 1'b0);
                     agg_mask_q[move_from_q] <= 1'b1;
                     state_q                 <= S_ADIS;
                  end
               end
               S_ADIS: begin
                  cmd_q   <= find_aggr(victim_q);
                  wait_q  <= SETTLE_LD;
                  state_q <= S_AWAIT;
               end
               S_RESTORE: begin
                  if (agg_mask_q != 64'd0) begin
                     cmd_q              <= set_en(low_sq, 1'b1);
                     agg_mask_q[low_sq] <= 1'b0;
                  end else begin
                     cmd_q   <= set_en(victim_q, 1'b0);
                     state_q <= S_VDIS;
                  end
               end
               S_VDIS: begin
                  cmd_q   <= 16'hE000;
                  wait_q  <= SETTLE_LD;
                  state_q <= S_VWAIT;
               end
               S_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign illegal    = illegal_q;
   assign cmd_addr   = cmd_q[15:8];
   assign cmd_data   = cmd_q[7:0];
   assign move_valid = move_valid_q;
   assign move_from  = move_from_q;
   assign move_to    = move_to_q;
   assign move_count = move_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: scripted core responses, expected command
// and move streams queued per scenario, checked by an independent bus monitor.
module tb_capture_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       move_ready = 1'b1;
   logic [7:0] core_result = 8'h40;
   logic       busy, done, illegal, move_valid;
   logic [7:0] cmd_addr, cmd_data, move_count;
   logic [5:0] move_from, move_to;

   capture_sequencer #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .illegal(illegal),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .core_result(core_result),
      .move_valid(move_valid), .move_ready(move_ready),
      .move_from(move_from), .move_to(move_to), .move_count(move_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;
   int t0 = 0;
   int cmd_idx = 0;
   int cmd_rel [2];
   int done_cnt = 0;
   logic [15:0] exp_cmd [$];
   logic [11:0] exp_mv [$];
   logic [7:0]  vq [$];
   logic [7:0]  aq [$];

   always @(posedge clk) cycle_cnt++;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
      end
   endtask

   // Core stand-in: each FIND command loads the next scripted answer (default none-found).
   always @(negedge clk) begin
      if (cmd_addr == 8'hE0)
         core_result = (vq.size() > 0) ? vq.pop_front() : 8'h40;
      else if (cmd_addr[7:2] == 6'b111100)
         core_result = (aq.size() > 0) ? aq.pop_front() : 8'h40;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if ({cmd_addr, cmd_data} != 16'h0000) begin
            if (cmd_idx < 2) begin
               cmd_rel[cmd_idx] = cycle_cnt - t0 + 1;
               cmd_idx++;
            end
            $display("cmd %02h/%02h", cmd_addr, cmd_data);
            if (exp_cmd.size() == 0) chk("cmd_unexpected", int'({cmd_addr, cmd_data}), 0);
            else chk("cmd", int'({cmd_addr, cmd_data}), int'(exp_cmd.pop_front()));
         end
         if (move_valid && move_ready) begin
            $display("move from=%0d to=%0d", move_from, move_to);
            if (exp_mv.size() == 0) chk("move_unexpected", int'({move_from, move_to}), 0);
            else chk("move", int'({move_from, move_to}), int'(exp_mv.pop_front()));
         end
         if (done) done_cnt++;
      end
   end

   task automatic pc(input logic [7:0] a, input logic [7:0] d);
      exp_cmd.push_back({a, d});
   endtask

   task automatic pm(input int f, input int t);
      exp_mv.push_back({6'(f), 6'(t)});
   endtask

   task automatic start_run();
      cmd_idx  = 0;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      t0    = cycle_cnt;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, output int rel);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 300);
      rel = cycle_cnt - t0 + 1;
      chk({nm, "_done_seen"}, int'(done), 1);
      chk({nm, "_busy_in_done"}, int'(busy), 1);
      @(negedge clk);
      chk({nm, "_busy_after"}, int'(busy), 0);
      chk({nm, "_done_pulse"}, int'(done), 0);
      chk({nm, "_cmds_left"}, exp_cmd.size(), 0);
      chk({nm, "_moves_left"}, exp_mv.size(), 0);
   endtask

   task automatic run_empty(input string nm);
      int rel;
      pc(8'hC0, 8'h00); pc(8'hE0, 8'h00);
      start_run();
      wait_done(nm, rel);
      chk({nm, "_c0_cycle"}, cmd_rel[0], 1);
      chk({nm, "_e0_cycle"}, cmd_rel[1], 2);
      chk({nm, "_done_cycle"}, rel, 5);
      chk({nm, "_count"}, int'(move_count), 0);
      chk({nm, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic push_single();
      vq.push_back(8'd27); aq.push_back(8'd10);
      pc(8'hC0, 8'h00); pc(8'hE0, 8'h00); pc(8'hF1, 8'hB0); pc(8'hD0, 8'hA0);
      pc(8'hF1, 8'hB0); pc(8'hD0, 8'hA1); pc(8'hD1, 8'hB0); pc(8'hE0, 8'h00);
      pm(10, 27);
   endtask

   initial begin
      int rel;
      int n;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_valid", int'(move_valid), 0);
      chk("rst_from", int'(move_from), 0);
      chk("rst_to", int'(move_to), 0);
      chk("rst_count", int'(move_count), 0);
      chk("rst_cmd", int'({cmd_addr, cmd_data}), 0);
      rst_n = 1'b1;

      run_empty("empty");

      push_single();
      start_run();
      wait_done("single", rel);
      chk("single_count", int'(move_count), 1);

      // Backpressure: consumer stalls while the move is presented.
      push_single();
      move_ready = 1'b0;
      start_run();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!move_valid && n < 100);
      chk("bp_valid_seen", int'(move_valid), 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid_hold", int'(move_valid), 1);
         chk("bp_from_hold", int'(move_from), 10);
         chk("bp_to_hold", int'(move_to), 27);
         chk("bp_cmd_nop", int'({cmd_addr, cmd_data}), 0);
         chk("bp_count_hold", int'(move_count), 0);
      end
      @(posedge clk);
      #1;
      move_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_valid_drop", int'(move_valid), 0);
      chk("bp_count_inc", int'(move_count), 1);
      wait_done("bp", rel);
      chk("bp_count_final", int'(move_count), 1);

      vq.push_back(8'h85);
      pc(8'hC0, 8'h00); pc(8'hE0, 8'h00);
      start_run();
      wait_done("illegal", rel);
      chk("illegal_flag", int'(illegal), 1);
      chk("illegal_count", int'(move_count), 0);

      // Two aggressors on one victim, then restores lowest square first.
      vq.push_back(8'd40); aq.push_back(8'd33); aq.push_back(8'd12);
      pc(8'hC0, 8'h00); pc(8'hE0, 8'h00); pc(8'hF2, 8'h80); pc(8'hD2, 8'h10);
      pc(8'hF2, 8'h80); pc(8'hD0, 8'hC0); pc(8'hF2, 8'h80); pc(8'hD0, 8'hC1);
      pc(8'hD2, 8'h11); pc(8'hD2, 8'h80); pc(8'hE0, 8'h00);
      pm(33, 40); pm(12, 40);
      start_run();
      chk("multi_illegal_cleared", int'(illegal), 0);
      wait_done("multi", rel);
      chk("multi_count", int'(move_count), 2);

      // Abort in the ADIS cycle.
      vq.push_back(8'd27); aq.push_back(8'd10);
      pc(8'hC0, 8'h00); pc(8'hE0, 8'h00); pc(8'hF1, 8'hB0); pc(8'hD0, 8'hA0);
      pm(10, 27);
      start_run();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ({cmd_addr, cmd_data} != 16'hD0A0 && n < 100);
      chk("abort_adis_seen", int'({cmd_addr, cmd_data}), 16'hD0A0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_cmd", int'({cmd_addr, cmd_data}), 0);
      chk("abort_valid", int'(move_valid), 0);
      chk("abort_done", int'(done), 0);
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_cmds_left", exp_cmd.size(), 0);
      vq.delete();
      aq.delete();
      run_empty("after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
